// File: rtl/ldpc_cn_sched.sv
// Min-sum check-node sequencer: accumulates one row of v2c messages, then streams
// the saturated c2v messages back out with valid/ready handshaking on both sides.
module ldpc_cn_sched #(
    parameter  int MAX_DEG = 32,
    parameter  int DW      = 8,
    localparam int IW      = $clog2(MAX_DEG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [IW:0]   deg_i,
    output logic          busy_o,
    output logic          err_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [DW-2:0] MIN_INIT = {(DW-1){1'b1}};
    localparam logic [IW:0]   CNT_ZERO = {(IW+1){1'b0}};
    localparam logic [IW:0]   CNT_ONE  = {{IW{1'b0}}, 1'b1};

    state_t               state_r;
    logic [IW:0]          deg_r;
    logic [IW:0]          cnt_r;
    logic [IW:0]          idx_r;
    logic [DW-2:0]        min1_r;
    logic [DW-2:0]        min2_r;
    logic                 parity_r;
    logic [MAX_DEG-1:0]   sign_r;

    logic [DW-2:0]        mag_s;
    logic                 sgn_s;
    logic [DW-2:0]        nxt_min1_s;
    logic [DW-2:0]        nxt_min2_s;
    logic [IW:0]          nxt_idx_s;
    logic                 nxt_parity_s;
    logic [MAX_DEG-1:0]   nxt_sign_s;
    logic [IW:0]          nxt_cnt_s;
    logic                 in_fire_s;
    logic                 out_fire_s;
    logic                 deg_ok_s;
    logic                 cnt_last_s;

    // -128 has no positive counterpart in int8, so it saturates to 127.
    function automatic logic [DW-2:0] sat_abs(input logic [DW-1:0] x);
        logic [DW-1:0] neg;
        neg = ~x + {{(DW-1){1'b0}}, 1'b1};
        if (x == {1'b1, {(DW-1){1'b0}}}) begin
            return {(DW-1){1'b1}};
        end else if (x[DW-1]) begin
            return neg[DW-2:0];
        end else begin
            return x[DW-2:0];
        end
    endfunction

    function automatic logic [DW-1:0] c2v(
        input logic [DW-2:0]      m1,
        input logic [DW-2:0]      m2,
        input logic [IW:0]        id,
        input logic [IW:0]        i,
        input logic               par,
        input logic [MAX_DEG-1:0] sv
    );
        logic [DW-1:0] m;
        logic          sg;
        m  = (i == id) ? {1'b0, m2} : {1'b0, m1};
        sg = par ^ sv[i[IW-1:0]];
        return sg ? (~m + {{(DW-1){1'b0}}, 1'b1}) : m;
    endfunction

    // Next-state of the running min1/min2/idx/parity/sign accumulation for one input.
    always_comb begin
        in_fire_s    = in_valid_i & in_ready_o;
        out_fire_s   = out_valid_o & out_ready_i;
        deg_ok_s     = (deg_i >= (IW+1)'(2)) && (deg_i <= (IW+1)'(MAX_DEG));
        cnt_last_s   = (cnt_r == (deg_r - CNT_ONE));
        nxt_cnt_s    = cnt_r + CNT_ONE;
        mag_s        = sat_abs(in_data_i);
        sgn_s        = in_data_i[DW-1];
        nxt_min1_s   = min1_r;
        nxt_min2_s   = min2_r;
        nxt_idx_s    = idx_r;
        nxt_parity_s = parity_r ^ sgn_s;
        nxt_sign_s   = sign_r;
        nxt_sign_s[cnt_r[IW-1:0]] = sgn_s;
        // Strict less-than keeps the earliest index on ties.
        if (mag_s < min1_r) begin
            nxt_min2_s = min1_r;
            nxt_min1_s = mag_s;
            nxt_idx_s  = cnt_r;
        end else if (mag_s < min2_r) begin
            nxt_min2_s = mag_s;
        end else begin
            nxt_min2_s = min2_r;
        end
    end

    // Row sequencer with all outputs registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            deg_r       <= CNT_ZERO;
            cnt_r       <= CNT_ZERO;
            idx_r       <= CNT_ZERO;
            min1_r      <= MIN_INIT;
            min2_r      <= MIN_INIT;
            parity_r    <= 1'b0;
            sign_r      <= {MAX_DEG{1'b0}};
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= {DW{1'b0}};
            out_last_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            err_o  <= 1'b0;
            done_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        if (deg_ok_s) begin
                            deg_r      <= deg_i;
                            cnt_r      <= CNT_ZERO;
                            idx_r      <= CNT_ZERO;
                            min1_r     <= MIN_INIT;
                            min2_r     <= MIN_INIT;
                            parity_r   <= 1'b0;
                            sign_r     <= {MAX_DEG{1'b0}};
                            busy_o     <= 1'b1;
                            in_ready_o <= 1'b1;
                            state_r    <= ACCUM;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_fire_s) begin
                        min1_r   <= nxt_min1_s;
                        min2_r   <= nxt_min2_s;
                        idx_r    <= nxt_idx_s;
                        parity_r <= nxt_parity_s;
                        sign_r   <= nxt_sign_s;
                        if (cnt_last_s) begin
                            // First output is formed from the just-updated row state.
                            cnt_r       <= CNT_ZERO;
                            in_ready_o  <= 1'b0;
                            out_valid_o <= 1'b1;
                            out_last_o  <= 1'b0;
                            out_data_o  <= c2v(nxt_min1_s, nxt_min2_s, nxt_idx_s,
                                               CNT_ZERO, nxt_parity_s, nxt_sign_s);
                            state_r     <= EMIT;
                        end else begin
                            cnt_r <= nxt_cnt_s;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire_s) begin
                        if (cnt_last_s) begin
                            cnt_r       <= CNT_ZERO;
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            out_data_o  <= {DW{1'b0}};
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            state_r     <= IDLE;
                        end else begin
                            cnt_r      <= nxt_cnt_s;
                            out_data_o <= c2v(min1_r, min2_r, idx_r, nxt_cnt_s,
                                              parity_r, sign_r);
                            out_last_o <= (nxt_cnt_s == (deg_r - CNT_ONE));
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_cn_sched.sv
// Directed bench for ldpc_cn_sched: hand-computed rows, illegal starts, a stalled
// row against an exclusive-min reference, and a mid-row reset.
module tb_ldpc_cn_sched;

    localparam int MAX_DEG = 32;
    localparam int IW      = 5;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [IW:0]  deg_i;
    logic         busy_o;
    logic         err_o;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [7:0]   out_data_o;
    logic         out_last_o;
    logic         done_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [7:0] xin  [0:31];
    logic        [7:0] xexp [0:31];

    ldpc_cn_sched #(.MAX_DEG(MAX_DEG), .DW(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .deg_i(deg_i),
        .busy_o(busy_o), .err_o(err_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: each output is the min magnitude and sign product over the other inputs.
    function automatic logic [7:0] model_out(input int deg, input int i);
        int mn;
        int mag;
        bit s;
        logic [7:0] r;
        mn = 127;
        s  = 1'b0;
        for (int j = 0; j < deg; j++) begin
            if (j != i) begin
                mag = (xin[j] == -8'sd128) ? 127 : ((xin[j] < 0) ? -int'(xin[j]) : int'(xin[j]));
                if (mag < mn) mn = mag;
                s = s ^ xin[j][7];
            end
        end
        r = 8'(mn);
        return s ? (~r + 8'd1) : r;
    endfunction

    task automatic run_row(input int deg, input bit stall, input bit poke, input string tag);
        int ii;
        int oi;
        int n;
        bit got_done;
        bit held_v;
        logic [7:0] held;
        ii = 0; oi = 0; n = 0; got_done = 1'b0; held_v = 1'b0; held = 8'd0;
        @(posedge clk); #1;
        start_i = 1'b1; deg_i = (IW+1)'(deg); in_valid_i = 1'b0; out_ready_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, "_busy_up"}, 32'(busy_o), 32'd1);
        check({tag, "_rdy_up"}, 32'(in_ready_o), 32'd1);
        while (!got_done && n < 400) begin
            in_valid_i  = (ii < deg) && (!stall || ($urandom_range(0, 3) != 0));
            in_data_i   = (ii < deg) ? xin[ii] : 8'd0;
            out_ready_i = !stall || ($urandom_range(0, 2) != 0);
            start_i     = poke && (oi < deg) && ($urandom_range(0, 3) == 0);
            deg_i       = (IW+1)'(3);
            @(negedge clk);
            if (poke) check({tag, "_no_err"}, 32'(err_o), 32'd0);
            if (held_v && out_valid_o) check({tag, "_stable"}, 32'(out_data_o), 32'(held));
            if (done_o) begin
                got_done = 1'b1;
                check({tag, "_count"}, 32'(oi), 32'(deg));
                if (!stall) check({tag, "_latency"}, 32'(n), 32'(2 * deg));
            end
            if (in_valid_i && in_ready_o) ii++;
            if (out_valid_o) begin
                if (out_ready_i) begin
                    check({tag, "_data"}, 32'(out_data_o), 32'(xexp[oi]));
                    check({tag, "_last"}, 32'(out_last_o), 32'(oi == deg - 1));
                    oi++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held   = out_data_o;
                end
            end else begin
                held_v = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        if (!got_done) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_busy_down"}, 32'(busy_o), 32'd0);
    endtask

    task automatic bad_start(input int deg, input string tag);
        @(posedge clk); #1;
        start_i = 1'b1; deg_i = (IW+1)'(deg);
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, "_err"}, 32'(err_o), 32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        check({tag, "_err_clr"}, 32'(err_o), 32'd0);
        check({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready_o), 32'd0);
        check({tag, "_oval"}, 32'(out_valid_o), 32'd0);
        check({tag, "_olast"}, 32'(out_last_o), 32'd0);
        check({tag, "_odata"}, 32'(out_data_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; deg_i = '0;
        in_valid_i = 1'b0; in_data_i = 8'd0; out_ready_i = 1'b0;
        #2;
        check_reset_vals("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_i = 1'b0;

        xin[0] = 8'sd5; xin[1] = -8'sd3; xin[2] = 8'sd7; xin[3] = -8'sd128;
        xexp[0] = 8'h03; xexp[1] = 8'hFB; xexp[2] = 8'h03; xexp[3] = 8'hFD;
        run_row(4, 1'b0, 1'b0, "deg4");

        xin[0] = -8'sd4; xin[1] = -8'sd4;
        xexp[0] = 8'hFC; xexp[1] = 8'hFC;
        run_row(2, 1'b0, 1'b0, "tie");

        xin[0] = 8'sd0; xin[1] = 8'sd0; xin[2] = 8'sd1;
        xexp[0] = 8'h00; xexp[1] = 8'h00; xexp[2] = 8'h00;
        run_row(3, 1'b0, 1'b0, "zero");

        bad_start(1, "deg1");
        bad_start(MAX_DEG + 1, "deg33");

        for (int k = 0; k < MAX_DEG; k++) begin
            xin[k]  = 8'sd127;
            xexp[k] = 8'h7F;
        end
        run_row(MAX_DEG, 1'b0, 1'b0, "max");

        xin[0] = 8'sd12;  xin[1] = -8'sd7; xin[2] = 8'sd0;   xin[3] = -8'sd128;
        xin[4] = 8'sd3;   xin[5] = -8'sd3; xin[6] = 8'sd100; xin[7] = -8'sd50;
        for (int k = 0; k < 8; k++) xexp[k] = model_out(8, k);
        run_row(8, 1'b1, 1'b1, "stall");

        // Park a deg=4 row in EMIT under backpressure, then reset it mid-cycle.
        xin[0] = 8'sd5; xin[1] = -8'sd3; xin[2] = 8'sd7; xin[3] = -8'sd128;
        @(posedge clk); #1;
        start_i = 1'b1; deg_i = (IW+1)'(4);
        @(posedge clk); #1;
        start_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data_i = xin[k];
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        check("pre_rst_oval", 32'(out_valid_o), 32'd1);
        check("pre_rst_odata", 32'(out_data_o), 32'h03);
        @(negedge clk); #2;
        rst_i = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_nodone", 32'(done_o), 32'd0);
            check("post_rst_idle", 32'(busy_o), 32'd0);
        end

        xin[0] = 8'sd9; xin[1] = -8'sd20;
        xexp[0] = 8'hEC; xexp[1] = 8'h09;
        run_row(2, 1'b0, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
